// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared state encoding and word/group widths for the transmitter arbiter.
package tx_arb_pkg;
  localparam int TX_WORD_W = 32;
  localparam int TX_GROUPS = 4;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/tx_arb_pick.sv
// tx_arb_pick: combinational winner selection among requesters.
// TX_ARB_ROUND_ROBIN_EN selects round-robin from rr_ptr+1; otherwise lowest index wins.
module tx_arb_pick
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  input  logic [NUM_REQ-1:0] reservation,
  output logic               valid,
  output logic [IDXW-1:0]    idx
);
  logic [NUM_REQ-1:0] cand;
  logic [IDXW-1:0]    j;
  assign cand = req & reservation;
`ifdef TX_ARB_ROUND_ROBIN_EN
  // Scan from farthest to nearest so the entry right after rr_ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
      if (cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr_ptr;
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDXW'(k);
      if (cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end
`endif
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial transmitter among word sources, with lock-based packet ownership.
// Arbitration is round-robin when TX_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [TX_WORD_W*NUM_REQ-1:0]   req_data,
  input  logic [TX_GROUPS*NUM_REQ-1:0]   req_dis,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           tx_busy,
  output logic                           tx_write,
  output logic [TX_WORD_W-1:0]           tx_wrdata,
  output logic [TX_GROUPS-1:0]           tx_disabledGroups,
  output logic [IDXW-1:0]                owner,
  output logic                           active
);
  state_e                 state_q, state_d;
  logic [IDXW-1:0]        owner_q, owner_d, sel, rr_ptr, pick_idx;
  logic [TX_WORD_W-1:0]   data_q, data_d, sel_data;
  logic [TX_GROUPS-1:0]   dis_q, dis_d, sel_dis;
  logic [NUM_REQ-1:0]     ack_q, ack_d, resv_mask;
  logic                   write_q, write_d, resv_q, resv_d, issue, pick_valid;

  // A held reservation narrows the candidates to the locked owner until its lock drops.
  assign resv_mask = (resv_q && lock[owner_q]) ? NUM_REQ'(1) << owner_q : '1;

  tx_arb_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_pick (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .reservation (resv_mask),
    .valid       (pick_valid),
    .idx         (pick_idx)
  );

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) rr_q <= IDXW'(NUM_REQ - 1);
    else rr_q <= (issue && state_q == IDLE) ? sel : rr_q;
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = IDXW'(NUM_REQ - 1);
`endif

  always_comb begin
    sel_data = '0;
    sel_dis  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IDXW'(k)) begin
        sel_data = req_data[k*TX_WORD_W +: TX_WORD_W];
        sel_dis  = req_dis[k*TX_GROUPS +: TX_GROUPS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    dis_d   = dis_q;
    write_d = 1'b0;
    ack_d   = '0;
    resv_d  = resv_q && lock[owner_q];
    issue   = 1'b0;
    sel     = pick_idx;
    case (state_q)
      IDLE: if (!tx_busy && pick_valid) begin
        issue  = 1'b1;
        resv_d = 1'b0;
      end
      WAIT_BUSY: state_d = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: if (!tx_busy) begin
        if (lock[owner_q] && req[owner_q]) begin
          issue = 1'b1;
          sel   = owner_q;
        end else begin
          state_d = IDLE;
          resv_d  = lock[owner_q];
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d = WAIT_BUSY;
      owner_d = sel;
      data_d  = sel_data;
      dis_d   = sel_dis;
      write_d = 1'b1;
      ack_d   = NUM_REQ'(1) << sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      data_q  <= '0;
      dis_q   <= '0;
      write_q <= 1'b0;
      ack_q   <= '0;
      resv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      dis_q   <= dis_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      resv_q  <= resv_d;
    end
  end

  assign ack               = ack_q;
  assign tx_write          = write_q;
  assign tx_wrdata         = data_q;
  assign tx_disabledGroups = dis_q;
  assign owner             = owner_q;
  assign active            = state_q != IDLE;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized and directed bench for tx_arbiter against a word-level reference model.
module tb_tx_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0, lock = '0;
  logic [32*N-1:0] req_data = '0;
  logic [4*N-1:0]  req_dis = '0;
  logic [N-1:0]    ack;
  logic            tx_busy = 1'b0;
  logic            tx_write;
  logic [31:0]     tx_wrdata;
  logic [3:0]      tx_disabledGroups;
  logic [IW-1:0]   owner;
  logic            active;

  tx_arbiter #(.NUM_REQ(N), .IDXW(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock), .req_data(req_data),
    .req_dis(req_dis), .ack(ack), .tx_busy(tx_busy), .tx_write(tx_write),
    .tx_wrdata(tx_wrdata), .tx_disabledGroups(tx_disabledGroups), .owner(owner),
    .active(active)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is "pending" from its write until the transmitter has
  // been seen busy and then free again; grants follow the policy rules directly.
  bit          m_pend, m_seen, m_resv, m_write;
  int          m_owner, m_rr;
  logic [31:0] m_data;
  logic [3:0]  m_dis;
  logic [N-1:0] m_ack;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend = 0; m_seen = 0; m_resv = 0; m_write = 0;
      m_owner = 0; m_rr = N - 1; m_data = '0; m_dis = '0; m_ack = '0;
    end else begin : model
      int win, j;
      win = -1;
      m_write = 0;
      m_ack = '0;
      if (!m_pend) begin
        m_resv = m_resv && lock[m_owner];
        if (!tx_busy) begin
          if (m_resv) win = req[m_owner] ? m_owner : -1;
          else
            for (int k = 0; k < N; k++) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
              j = (m_rr + 1 + k) % N;
`else
              j = k;
`endif
              if (win < 0 && req[j]) win = j;
            end
          if (win >= 0) begin
            m_resv = 0;
            m_rr = win;
          end
        end
      end else if (!m_seen) m_seen = tx_busy;
      else if (!tx_busy) begin
        if (lock[m_owner] && req[m_owner]) win = m_owner;
        else begin
          m_pend = 0;
          m_resv = lock[m_owner];
        end
      end
      if (win >= 0) begin
        m_pend = 1; m_seen = 0; m_owner = win; m_write = 1;
        m_data = req_data[32*win +: 32];
        m_dis  = req_dis[4*win +: 4];
        m_ack[win] = 1'b1;
      end
    end
  end

  // Per-cycle compare, write log and transmitter model (busy rises one cycle after write).
  int cyc = 0, fall_cyc = 0, busy_cnt = 0, n_acks = 0;
  bit wr_seen = 0, prev_write = 0, xoff = 0, nb;
  int wlog[$], wgap[$];

  always @(negedge clock) begin
    cyc++;
    chk("tx_write", tx_write, m_write);
    chk("ack", ack, m_ack);
    chk("owner", owner, m_owner);
    chk("active", active, m_pend);
    chk("tx_wrdata", tx_wrdata, m_data);
    chk("tx_disabledGroups", tx_disabledGroups, m_dis);
    chk("write_while_busy", tx_write & tx_busy, 0);
    chk("write_back_to_back", tx_write & prev_write, 0);
    if (tx_write) begin
      wlog.push_back(int'(owner));
      wgap.push_back(cyc - fall_cyc);
    end
    if (ack != '0) n_acks++;
    if (wr_seen) busy_cnt = $urandom_range(1, 5);
    else if (busy_cnt > 0) busy_cnt--;
    wr_seen = tx_write;
    prev_write = tx_write;
    nb = xoff || busy_cnt > 0;
    if (tx_busy && !nb) fall_cyc = cyc;
    tx_busy = nb;
  end

  // Requesters: on ack present a fresh word, drop req after the last one.
  int left[N];
  task automatic step();
    @(negedge clock);
    for (int i = 0; i < N; i++)
      if (ack[i]) begin
        if (left[i] > 0) left[i]--;
        req_data[32*i +: 32] = $urandom;
        req_dis[4*i +: 4] = 4'($urandom);
        if (left[i] == 0) req[i] = 1'b0;
      end
    #1;
  endtask

  task automatic do_reset();
    xoff = 0; req = '0; lock = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    wlog.delete(); wgap.delete();
  endtask

  task automatic wait_writes(input int target, input int budget);
    int t;
    t = 0;
    while (wlog.size() < target && t < budget) begin step(); t++; end
    chk("write_count", wlog.size(), target);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (active && t < budget) begin step(); t++; end
    chk("reach_idle", active, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n0, r;
    #1;
    chk("reset_write", tx_write, 0);
    chk("reset_owner", owner, 0);
    chk("reset_active", active, 0);
    chk("reset_data", tx_wrdata, 0);
    do_reset();

    // Single word
    req_data[63:32] = 32'h534C4131; req_dis[7:4] = 4'h5;
    left[1] = 1; req[1] = 1'b1;
    step();
    chk("single_write", tx_write, 1);
    chk("single_ack", ack, 3'b010);
    chk("single_data", tx_wrdata, 32'h534C4131);
    chk("single_dis", tx_disabledGroups, 4'h5);
    chk("single_owner", owner, 1);
    step();
    chk("single_write_off", tx_write, 0);
    wait_idle(50);
    chk("single_count", wlog.size(), 1);

    // Simultaneous requests held for 3 words
    do_reset();
    for (int i = 0; i < N; i++) left[i] = 100;
    req = 3'b111;
    wait_writes(3, 200);
    req = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int k = 0; k < 3; k++)
`ifdef TX_ARB_ROUND_ROBIN_EN
      chk("simul_order", wlog[k], k);
`else
      chk("simul_order", wlog[k], 0);
`endif
    wait_idle(50);

    // Locked burst of 4 from requester 2 while requester 0 waits
    do_reset();
    left[2] = 4; lock[2] = 1'b1; req[2] = 1'b1;
    wait_writes(1, 20);
    left[0] = 1; req[0] = 1'b1;
    wait_writes(4, 200);
    lock[2] = 1'b0;
    wait_writes(5, 100);
    for (int k = 0; k < 4; k++) chk("burst_owner", wlog[k], 2);
    chk("burst_then_0", wlog[4], 0);
    for (int k = 1; k < 4; k++) chk("burst_gap", wgap[k], 1);
    chk("unlocked_gap", wgap[4], 2);
    wait_idle(50);

    // Reservation held while requester 2 pauses with lock high
    do_reset();
    left[2] = 1; lock[2] = 1'b1; req[2] = 1'b1;
    wait_writes(1, 20);
    left[0] = 1; req[0] = 1'b1;
    wait_idle(50);
    for (int k = 0; k < 10; k++) step();
    chk("resv_no_grant", wlog.size(), 1);
    left[2] = 1; req[2] = 1'b1;
    wait_writes(2, 20);
    lock[2] = 1'b0;
    wait_writes(3, 100);
    chk("resv_owner1", wlog[1], 2);
    chk("resv_owner2", wlog[2], 0);
    wait_idle(50);

    // Transmitter paused for 500 cycles
    do_reset();
    xoff = 1; step(); step();
    left[1] = 1; req[1] = 1'b1;
    n0 = wlog.size(); a0 = n_acks;
    for (int k = 0; k < 500; k++) step();
    chk("pause_writes", wlog.size(), n0);
    chk("pause_acks", n_acks, a0);
    chk("pause_active", active, 0);
    xoff = 0;
    wait_writes(n0 + 1, 20);
    wait_idle(50);

    // Reset while waiting for the word to finish
    do_reset();
    left[1] = 1; req[1] = 1'b1;
    wait_writes(1, 20);
    xoff = 1;
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_active", active, 1);
    reset = 1'b1;
    #1;
    chk("rst_write", tx_write, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", tx_wrdata, 0);
    chk("rst_dis", tx_disabledGroups, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);
    step();
    reset = 1'b0; xoff = 0;
    wlog.delete(); wgap.delete();
    left[0] = 1; left[2] = 1; req = 3'b101;
    wait_writes(1, 100);
    chk("post_reset_first", wlog[0], 0);
    wait_writes(2, 100);
    chk("post_reset_second", wlog[1], 2);
    wait_idle(50);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 63);
        if (!req[i] && r < 12) begin
          left[i] = $urandom_range(1, 4);
          req_data[32*i +: 32] = $urandom;
          req_dis[4*i +: 4] = 4'($urandom);
          req[i] = 1'b1;
        end else if (r == 63) req[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) lock[i] = ~lock[i];
      end
      if ($urandom_range(0, 299) == 0) xoff = ~xoff;
      step();
    end
    req = '0; lock = '0; xoff = 0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
